osdinfo_queue: RTL

- Parametrised successor to the C128 OSD info notifier.
- Watches NCH sense inputs and one fatal ROM-load watchdog, and emits 8-bit OSD info codes on a single-cycle request strobe.
- Queues changes that occur together so none is lost, and enforces a minimum on-screen hold time between messages.
- Sits between keyboard/video status senses and the hps_io OSD info port.

---
 rtl/osdinfo_pkg.sv | 23 ++
 rtl/osd_tick_gen.sv | 24 ++
 rtl/osdinfo_queue.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/osdinfo_pkg.sv
// Shared types, default codes and the message-code arithmetic for the OSD info queue.
package osdinfo_pkg;

    typedef logic [7:0] info_t;

    typedef enum logic [1:0] {
        MODE_BLANK,
        MODE_FATAL,
        MODE_RUN
    } osd_mode_e;

    localparam int OSD_FATAL_CODE = 1;
    localparam int OSD_MSG_BASE   = 2;

    // Code wraps to 8 bits so large NCH/base combinations stay well defined.
    function automatic info_t msg_code(input int idx, input logic val, input logic alt,
                                       input int base, input int alt_off);
        int s;
        s = base + 2 * idx + int'(val) + (alt ? alt_off : 0);
        return s[7:0];
    endfunction

endpackage

// File: rtl/osd_tick_gen.sv
// Free-running down-counter that pulses tick_o for one cycle each time it passes zero.
module osd_tick_gen #(
    parameter int TICK_BITS = 20
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    localparam logic [TICK_BITS-1:0] DIV_ONE = TICK_BITS'(1);

    logic [TICK_BITS-1:0] div_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '1;
        end else begin
            div_q <= div_q - DIV_ONE;
        end
    end

    assign tick_o = (div_q == '0);

endmodule

// File: rtl/osdinfo_queue.sv
// OSD info notifier: per-channel change queue with fixed priority, hold timer,
// startup blanking and a fatal ROM-load watchdog.
module osdinfo_queue
    import osdinfo_pkg::*;
#(
    parameter int NCH            = 4,
    parameter int TICK_BITS      = 20,
    parameter int ROM_LOAD_DELAY = 255,
    parameter int STARTUP_DELAY  = 7,
    parameter int HOLD_TICKS     = 4,
    parameter int MSG_BASE       = OSD_MSG_BASE,
    parameter int ALT_OFFSET     = 2 * NCH,
    parameter int FATAL_CODE     = OSD_FATAL_CODE
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           kbd_reset,
    input  logic           rom_loaded,
    input  logic [NCH-1:0] sense,
    input  logic [NCH-1:0] alt_mode,
    output logic           info_req,
    output logic [7:0]     info,
    output logic           busy
);

    localparam int RW = (ROM_LOAD_DELAY < 1) ? 1 : $clog2(ROM_LOAD_DELAY + 1);
    localparam int SW = (STARTUP_DELAY < 1) ? 1 : $clog2(STARTUP_DELAY + 1);
    localparam int HW = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);
    localparam logic [RW-1:0] ROM_INIT  = RW'(ROM_LOAD_DELAY);
    localparam logic [SW-1:0] SU_INIT   = SW'(STARTUP_DELAY);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_TICKS);
    localparam logic [RW-1:0] ROM_ONE   = RW'(1);
    localparam logic [SW-1:0] SU_ONE    = SW'(1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    logic           tick;
    logic           kbd_q;
    logic [SW-1:0]  startup_q, startup_d;
    logic [RW-1:0]  rom_q, rom_d;
    logic           fatal_seen_q;
    logic [HW-1:0]  hold_q, hold_d;
    logic [NCH-1:0] pending_q, pending_d;
    logic [NCH-1:0] base_q;
    logic [NCH-1:0] val_q, val_d;
    logic [NCH-1:0] alt_q, alt_d;
    info_t          info_q, info_d;
    logic           req_q, req_d;

    logic           kbd_rise, fatal;
    osd_mode_e      mode;
    logic [NCH-1:0] chg, clr;
    int             sel_idx;
    logic           sel_val, sel_alt;

    osd_tick_gen #(.TICK_BITS(TICK_BITS)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick)
    );

    assign kbd_rise = kbd_reset & ~kbd_q;
    assign fatal    = (rom_q == '0);
    assign chg      = sense ^ base_q;

    always_comb begin
        if ((startup_q != '0) || kbd_rise) begin
            mode = MODE_BLANK;
        end else if (fatal) begin
            mode = MODE_FATAL;
        end else begin
            mode = MODE_RUN;
        end
    end

    // Fixed priority: the descending scan leaves the lowest pending index selected.
    always_comb begin
        sel_idx = 0;
        sel_val = 1'b0;
        sel_alt = 1'b0;
        clr     = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_idx = i;
                sel_val = val_q[i];
                sel_alt = alt_q[i];
                clr     = '0;
                clr[i]  = 1'b1;
            end
        end
    end

    always_comb begin
        startup_d = startup_q;
        rom_d     = rom_q;
        hold_d    = hold_q;
        pending_d = pending_q;
        val_d     = val_q;
        alt_d     = alt_q;
        info_d    = info_q;
        req_d     = 1'b0;

        if (kbd_rise) begin
            startup_d = SU_INIT;
        end else if (tick && (startup_q != '0)) begin
            startup_d = startup_q - SU_ONE;
        end

        if (rom_loaded) begin
            rom_d = ROM_INIT;
        end else if (tick && (rom_q != '0)) begin
            rom_d = rom_q - ROM_ONE;
        end

        if (tick && (hold_q != '0)) begin
            hold_d = hold_q - HOLD_ONE;
        end

        case (mode)
            MODE_BLANK: begin
                hold_d    = '0;
                pending_d = '0;
            end
            MODE_FATAL: begin
                hold_d = '0;
                if (tick || !fatal_seen_q) begin
                    req_d  = 1'b1;
                    info_d = info_t'(FATAL_CODE);
                end
            end
            default: begin
                if ((hold_q == '0) && (pending_q != '0)) begin
                    req_d  = 1'b1;
                    info_d = msg_code(sel_idx, sel_val, sel_alt, MSG_BASE, ALT_OFFSET);
                    hold_d = HOLD_INIT;
                end
            end
        endcase

        // A fresh change on the channel being emitted re-arms it with the new value.
        if (mode != MODE_BLANK) begin
            pending_d = (pending_q & ~(req_d && mode == MODE_RUN ? clr : '0)) | chg;
            for (int i = 0; i < NCH; i++) begin
                if (chg[i]) begin
                    val_d[i] = sense[i];
                    alt_d[i] = alt_mode[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kbd_q        <= kbd_reset;
            startup_q    <= SU_INIT;
            rom_q        <= ROM_INIT;
            fatal_seen_q <= 1'b0;
            hold_q       <= '0;
            pending_q    <= '0;
            base_q       <= sense;
            info_q       <= '0;
            req_q        <= 1'b0;
        end else begin
            kbd_q        <= kbd_reset;
            startup_q    <= startup_d;
            rom_q        <= rom_d;
            fatal_seen_q <= fatal;
            hold_q       <= hold_d;
            pending_q    <= pending_d;
            base_q       <= sense;
            info_q       <= info_d;
            req_q        <= req_d;
        end
    end

    always_ff @(posedge clk) begin
        val_q <= val_d;
        alt_q <= alt_d;
    end

    assign info_req = req_q;
    assign info     = info_q;
    assign busy     = (pending_q != '0) || (hold_q != '0);

endmodule
